consmax: RTL and testbench
==========================

CONSMAX -- requirements
Module: consmax

Interface
REQ-001 The block SHALL have the following parameters:
- IDATA_BIT, 8, input width.
- ODATA_BIT, 8, output width.
- CDATA_BIT, 8, shift-config width.
- EXP_BIT, 8, bf16 exponent width.
- MAT_BIT, 7, bf16 mantissa width.
- LUT_DATA, EXP_BIT+MAT_BIT+1 = 16, LUT word width.
- LUT_ADDR, IDATA_BIT/2 = 4, per-table index width.
- LUT_DEPTH, 2**LUT_ADDR = 16, entries per table.

REQ-002 The block SHALL have the following ports, each with a fixed direction and width:
- clk, input, 1, sole clock; all logic on its rising edge.
- rstn, input, 1, synchronous active-high reset (asserted when rstn=1).
- cfg_consmax_shift, input, 8, unsigned output scaling shift.
- lut_waddr, input, 5, bit4 selects the table (0 = low-nibble table, 1 = high-nibble table); bits 3:0 give the entry.
- lut_wen, input, 1, LUT write enable.
- lut_wdata, input, 16, bf16 word {sign, exp[7:0], man[6:0]}.
- idata, input, 8, input code.
- idata_valid, input, 1, input qualifier.
- odata, output, 8, signed two's-complement result.
- odata_valid, output, 1, result qualifier.

Function
REQ-003 The block SHALL compute odata = sat8(trunc(LUT_H[idata[7:4]] × LUT_L[idata[3:0]] / 2^cfg_consmax_shift)).
- This is exp(x) decomposed as exp(hi)·exp(lo) into two 16-entry bf16 tables.

REQ-004 A LUT write SHALL occur on a rising edge with lut_wen=1.
- The written word is visible to lookups from the next cycle onward.
- Writes and lookups SHALL be allowed in the same cycle; a same-cycle lookup of the same entry returns the old word.

REQ-005 The pipeline SHALL have exactly 3 cycles of latency, fully pipelined, accepting one input per cycle:
- S1: register both LUT reads, the sign/shift path, and valid.
- S2: bf16 multiply.
- S3: float-to-int conversion.

REQ-006 cfg_consmax_shift SHALL be sampled with idata in S1 and carried down the pipeline, so each sample uses its own shift.

REQ-007 The bf16 multiply SHALL work as follows:
- Result sign = XOR of the operand signs.
- Exponent = ea + eb − 127.
- Mantissa = (1.ma × 1.mb), normalized by at most 1 bit, truncated to 7 bits (no rounding).

REQ-008 The multiplier SHALL flush operands with exponent 0 to zero, so a zero operand gives a zero product.
- Exponent 255 SHALL be treated as an ordinary finite value (no Inf/NaN handling).

REQ-009 The multiplier SHALL clamp results: a biased result exponent below 1 gives zero, and above 254 clamps to 254 with mantissa 0x7F.

REQ-010 The float-to-int conversion SHALL work as follows:
- Effective exponent E = exp − 127 − shift.
- Magnitude = floor(1.m × 2^E); any E < 0 with a value below 1 gives 0.
- A zero product SHALL give 0.

REQ-011 The conversion SHALL saturate the magnitude at 127 and then apply the sign, so the output range is −127..+127 and −128 is never produced.

REQ-012 odata_valid SHALL equal idata_valid delayed by 3 cycles.
- odata SHALL update only when a valid result exits S3 and SHALL hold its value otherwise.

REQ-013 Back-to-back valid inputs SHALL produce back-to-back valid outputs, with no bubbles and no backpressure.

Reset
REQ-014 While rstn=1 at a rising edge, the block SHALL clear:
- all pipeline registers, with odata=0 and odata_valid=0;
- all 32 LUT entries, to 0x0000.

REQ-015 Inputs arriving while reset is asserted SHALL be ignored: no LUT writes occur and no valid is launched.

REQ-016 Reset asserted mid-operation SHALL discard all in-flight samples, and no odata_valid SHALL appear for them.

Verification
REQ-017 Unity: write L[0]=0x3F80 and H[0]=0x3F80, then apply idata=0x00, shift=0 -> after 3 cycles odata=0x01, odata_valid=1.

REQ-018 Product and shift:
- Write L[3]=0x4000 and H[2]=0x4040, then apply idata=0x23, shift=0 -> odata=6.
- The same with shift=1 -> odata=3.
- The same with shift=3 -> odata=0.

REQ-019 Sign and saturation:
- H[2]=0xBF80 with L[3]=0x4040, idata=0x23 -> odata=0xFD (−3).
- H[1]=0x4300 (128) with L[1]=0x4000, idata=0x11, shift=0 -> odata=0x7F.
- H[1]=0xC300 with L[1]=0x4000, idata=0x11, shift=0 -> odata=0x81.

REQ-020 Zero and flush: L[5]=0x0000 and H[0]=0x3F80, then apply idata=0x05 -> odata=0; an operand with exp=0 and man≠0 -> odata=0.

REQ-021 Streaming: 500 consecutive valid random inputs with random shifts after a random LUT load -> every output matches a reference model exactly, and odata_valid is high for exactly 500 cycles starting 3 cycles after the first input.

REQ-022 Reset mid-stream: assert rstn=1 for one cycle while 3 samples are in flight -> odata_valid stays 0, odata=0, and a subsequent lookup returns 0 because the LUT was cleared.

Source files
------------

// File: rtl/consmax.sv
// consmax: exp(x) approximation for an 8-bit code. The high and low nibbles
// index two 16-entry bf16 tables (exp(hi), exp(lo)). The two words are
// multiplied in bf16, scaled down by 2^shift and converted to a saturated
// signed 8-bit integer.
// Pipeline: S1 LUT read, S2 bf16 multiply, S3 float-to-int. Three cycles total.
module consmax #(
  parameter int IDATA_BIT = 8,
  parameter int ODATA_BIT = 8,
  parameter int CDATA_BIT = 8,
  parameter int EXP_BIT   = 8,
  parameter int MAT_BIT   = 7,
  parameter int LUT_DATA  = EXP_BIT + MAT_BIT + 1,
  parameter int LUT_ADDR  = IDATA_BIT / 2,
  parameter int LUT_DEPTH = 2 ** LUT_ADDR
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [CDATA_BIT-1:0] cfg_consmax_shift,
  input  logic [LUT_ADDR:0]    lut_waddr,
  input  logic                 lut_wen,
  input  logic [LUT_DATA-1:0]  lut_wdata,
  input  logic [IDATA_BIT-1:0] idata,
  input  logic                 idata_valid,
  output logic [ODATA_BIT-1:0] odata,
  output logic                 odata_valid
);

  localparam int STAGES = 3;
  localparam int BIAS   = (1 << (EXP_BIT - 1)) - 1;
  localparam int EMAX   = (1 << EXP_BIT) - 2;
  localparam int XW     = EXP_BIT + 2;
  localparam int EW     = ((EXP_BIT > CDATA_BIT) ? EXP_BIT : CDATA_BIT) + 2;
  localparam int SW     = $clog2(ODATA_BIT);
  localparam int PW     = 2 * MAT_BIT + 2;
  localparam int HW     = MAT_BIT + ODATA_BIT - 1;

  logic [LUT_DEPTH-1:0][LUT_DATA-1:0] lut_l_q, lut_l_d, lut_h_q, lut_h_d;
  logic [STAGES:1]      vld_pipe_q, vld_pipe_d;
  logic [LUT_DATA-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [CDATA_BIT-1:0] s1_shift_q, s1_shift_d, s2_shift_q, s2_shift_d;
  logic                 s2_sign_q, s2_sign_d;
  logic [EXP_BIT-1:0]   s2_exp_q, s2_exp_d;
  logic [MAT_BIT-1:0]   s2_man_q, s2_man_d;
  logic [ODATA_BIT-1:0] odata_q, odata_d;

  logic [EXP_BIT-1:0]   ea, eb;
  logic [MAT_BIT:0]     sa, sb;
  logic [PW-1:0]        prod;
  logic                 norm;
  logic [XW-1:0]        exp_sum;
  logic [EW-1:0]        e_eff;
  logic [SW-1:0]        shamt;
  logic [HW-1:0]        sh_sig;
  logic [ODATA_BIT-2:0] mag;
  logic                 unused_bits;

  // S1: LUT write port (lookups see the pre-write word) and table reads
  always_comb begin
    lut_l_d = lut_l_q;
    lut_h_d = lut_h_q;
    if (lut_wen) begin
      if (lut_waddr[LUT_ADDR]) lut_h_d[lut_waddr[LUT_ADDR-1:0]] = lut_wdata;
      else                     lut_l_d[lut_waddr[LUT_ADDR-1:0]] = lut_wdata;
    end
    s1_a_d     = lut_h_q[idata[IDATA_BIT-1 -: LUT_ADDR]];
    s1_b_d     = lut_l_q[idata[LUT_ADDR-1:0]];
    s1_shift_d = cfg_consmax_shift;
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], idata_valid};
  end

  // S2: bf16 multiply, truncating; exp==0 operands flush, result exponent clamps
  always_comb begin
    ea      = s1_a_q[LUT_DATA-2 -: EXP_BIT];
    eb      = s1_b_q[LUT_DATA-2 -: EXP_BIT];
    sa      = {1'b1, s1_a_q[MAT_BIT-1:0]};
    sb      = {1'b1, s1_b_q[MAT_BIT-1:0]};
    prod    = PW'(sa) * PW'(sb);
    norm    = prod[PW-1];
    exp_sum = XW'(ea) + XW'(eb) + XW'(norm) - XW'(BIAS);
    s2_sign_d  = s1_a_q[LUT_DATA-1] ^ s1_b_q[LUT_DATA-1];
    s2_exp_d   = exp_sum[EXP_BIT-1:0];
    s2_man_d   = norm ? prod[PW-2 -: MAT_BIT] : prod[PW-3 -: MAT_BIT];
    s2_shift_d = s1_shift_q;
    if (ea == '0 || eb == '0 || exp_sum[XW-1] || exp_sum == '0) begin
      s2_sign_d = 1'b0;
      s2_exp_d  = '0;
      s2_man_d  = '0;
    end else if (exp_sum > XW'(EMAX)) begin
      s2_exp_d = EXP_BIT'(EMAX);
      s2_man_d = '1;
    end
  end

  // S3: floor(1.m * 2^(exp-bias-shift)), saturate magnitude, then apply sign
  always_comb begin
    e_eff  = EW'(s2_exp_q) - EW'(BIAS) - EW'(s2_shift_q);
    shamt  = e_eff[SW-1:0];
    sh_sig = HW'({1'b1, s2_man_q}) << shamt;
    if (s2_exp_q == '0 || e_eff[EW-1]) mag = '0;
    else if (e_eff >= EW'(ODATA_BIT - 1)) mag = '1;
    else mag = sh_sig[MAT_BIT +: ODATA_BIT-1];
    odata_d = odata_q;
    if (vld_pipe_q[STAGES-1]) odata_d = s2_sign_q ? -{1'b0, mag} : {1'b0, mag};
  end

  // fraction bits dropped by truncation
  always_comb begin
    unused_bits = ^{prod[MAT_BIT-1:0], sh_sig[MAT_BIT-1:0]};
  end

  // state registers; reset clears tables and drops everything in flight
  always_ff @(posedge clk) begin
    if (rstn) begin
      lut_l_q    <= '0;
      lut_h_q    <= '0;
      vld_pipe_q <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_shift_q <= '0;
      s2_shift_q <= '0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_man_q   <= '0;
      odata_q    <= '0;
    end else begin
      lut_l_q    <= lut_l_d;
      lut_h_q    <= lut_h_d;
      vld_pipe_q <= vld_pipe_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_shift_q <= s1_shift_d;
      s2_shift_q <= s2_shift_d;
      s2_sign_q  <= s2_sign_d;
      s2_exp_q   <= s2_exp_d;
      s2_man_q   <= s2_man_d;
      odata_q    <= odata_d;
    end
  end

  assign odata       = odata_q;
  assign odata_valid = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_consmax.sv
// tb_consmax: directed vectors for consmax plus a random stream against a
// bit-exact integer reference model.
module tb_consmax;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [7:0]  cfg_consmax_shift = '0;
  logic [4:0]  lut_waddr = '0;
  logic        lut_wen = 1'b0;
  logic [15:0] lut_wdata = '0;
  logic [7:0]  idata = '0;
  logic        idata_valid = 1'b0;
  logic [7:0]  odata;
  logic        odata_valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] sh_h [16];
  logic [15:0] sh_l [16];
  logic [7:0]  expq [500];

  consmax dut (
    .clk(clk), .rstn(rstn), .cfg_consmax_shift(cfg_consmax_shift),
    .lut_waddr(lut_waddr), .lut_wen(lut_wen), .lut_wdata(lut_wdata),
    .idata(idata), .idata_valid(idata_valid),
    .odata(odata), .odata_valid(odata_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: exact integer product, truncated to 8 significant bits
  function automatic logic [7:0] ref_out(logic [15:0] h, logic [15:0] l, logic [7:0] sh);
    int ea, eb, p, e, sig, ee, mag, shi;
    ea = h[14:7]; eb = l[14:7]; shi = sh;
    if (ea == 0 || eb == 0) return 8'h00;
    p = (128 + h[6:0]) * (128 + l[6:0]);
    e = ea + eb - 127;
    if (p >= 32768) begin sig = p / 256; e++; end
    else sig = p / 128;
    if (e < 1) return 8'h00;
    if (e > 254) begin e = 254; sig = 255; end
    ee = e - 127 - shi;
    if (ee < 0) mag = 0;
    else if (ee >= 7) mag = 127;
    else mag = (sig << ee) / 128;
    if (mag > 127) mag = 127;
    return (h[15] ^ l[15]) ? 8'(-mag) : 8'(mag);
  endfunction

  function automatic logic [15:0] rnd_word();
    logic [7:0] e;
    e = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(118, 134));
    return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
  endfunction

  // all tasks start and end right after a falling edge
  task automatic lut_wr(input logic tbl, input logic [3:0] idx, input logic [15:0] w);
    lut_wen = 1'b1; lut_waddr = {tbl, idx}; lut_wdata = w;
    if (tbl) sh_h[idx] = w; else sh_l[idx] = w;
    @(negedge clk);
    lut_wen = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [7:0] code, input logic [7:0] sh, input logic [7:0] expv);
    idata = code; cfg_consmax_shift = sh; idata_valid = 1'b1;
    @(negedge clk);
    idata_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_vld"}, 16'(odata_valid), 16'd1);
    chk(tag, 16'(odata), 16'(expv));
    @(negedge clk);
    chk({tag, "_vld_off"}, 16'(odata_valid), 16'd0);
    chk({tag, "_hold"}, 16'(odata), 16'(expv));
  endtask

  initial begin
    int n_vld, first_vld;
    logic [7:0] c, s;
    for (int i = 0; i < 16; i++) begin sh_h[i] = '0; sh_l[i] = '0; end

    repeat (2) @(negedge clk);
    chk("rst_odata", 16'(odata), 16'd0);
    chk("rst_vld", 16'(odata_valid), 16'd0);
    rstn = 1'b0;

    lut_wr(0, 0, 16'h3F80); lut_wr(1, 0, 16'h3F80);
    run1("unity", 8'h00, 8'd0, 8'h01);
    lut_wr(0, 3, 16'h4000); lut_wr(1, 2, 16'h4040);
    run1("prod", 8'h23, 8'd0, 8'd6);
    run1("shift1", 8'h23, 8'd1, 8'd3);
    run1("shift3", 8'h23, 8'd3, 8'd0);
    lut_wr(1, 2, 16'hBF80); lut_wr(0, 3, 16'h4040);
    run1("neg", 8'h23, 8'd0, 8'hFD);
    lut_wr(1, 1, 16'h4300); lut_wr(0, 1, 16'h4000);
    run1("sat_pos", 8'h11, 8'd0, 8'h7F);
    lut_wr(1, 1, 16'hC300);
    run1("sat_neg", 8'h11, 8'd0, 8'h81);
    run1("e6_neg", 8'h10, 8'd1, 8'hC0);
    lut_wr(0, 5, 16'h0000);
    run1("zero", 8'h05, 8'd0, 8'h00);
    lut_wr(0, 6, 16'h0040);
    run1("flush", 8'h06, 8'd0, 8'h00);
    lut_wr(1, 4, 16'h7F80); lut_wr(0, 4, 16'h7F80);
    run1("ovf", 8'h44, 8'd0, 8'h7F);
    run1("ovf_shift", 8'h44, 8'd255, 8'h00);
    lut_wr(1, 7, 16'h0080); lut_wr(0, 7, 16'h0080);
    run1("unf", 8'h77, 8'd0, 8'h00);
    lut_wr(1, 8, 16'h42FF);
    run1("max_exact", 8'h80, 8'd0, 8'h7F);

    // write and lookup of the same entry in one cycle: old word wins
    lut_wen = 1'b1; lut_waddr = 5'h00; lut_wdata = 16'h4000; sh_l[0] = 16'h4000;
    idata = 8'h00; cfg_consmax_shift = 8'd0; idata_valid = 1'b1;
    @(negedge clk);
    lut_wen = 1'b0; idata_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("wr_rd_old", 16'(odata), 16'h01);
    @(negedge clk);
    run1("wr_rd_new", 8'h00, 8'd0, 8'h02);

    // random stream
    for (int i = 0; i < 16; i++) begin lut_wr(0, 4'(i), rnd_word()); lut_wr(1, 4'(i), rnd_word()); end
    n_vld = 0; first_vld = -1;
    for (int k = 0; k < 506; k++) begin
      chk("stream_vld", 16'(odata_valid), 16'(k >= 3 && k < 503));
      if (odata_valid) begin
        n_vld++;
        if (first_vld < 0) first_vld = k;
        if (k >= 3 && k < 503) chk("stream_data", 16'(odata), 16'(expq[k-3]));
      end
      if (k < 500) begin
        c = 8'($urandom_range(0, 255));
        s = 8'($urandom_range(0, 9));
        expq[k] = ref_out(sh_h[c[7:4]], sh_l[c[3:0]], s);
        idata = c; cfg_consmax_shift = s; idata_valid = 1'b1;
      end else idata_valid = 1'b0;
      @(negedge clk);
    end
    chk("stream_count", 16'(n_vld), 16'd500);
    chk("stream_first", 16'(first_vld), 16'd3);

    // reset with samples in flight; a write and a valid during reset are ignored
    lut_wr(1, 2, 16'h4000); lut_wr(0, 3, 16'h4000);
    idata = 8'h23; cfg_consmax_shift = 8'd0; idata_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1; lut_wen = 1'b1; lut_waddr = 5'h00; lut_wdata = 16'h3F80;
    @(negedge clk);
    rstn = 1'b0; lut_wen = 1'b0; idata_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("midrst_vld", 16'(odata_valid), 16'd0);
      chk("midrst_odata", 16'(odata), 16'd0);
      @(negedge clk);
    end
    run1("rst_lut_clr", 8'h23, 8'd0, 8'h00);
    lut_wr(1, 0, 16'h3F80);
    run1("rst_wen_ign", 8'h00, 8'd0, 8'h00);
    lut_wr(0, 0, 16'h3F80);
    run1("post_rst", 8'h00, 8'd0, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
